pulse_sync_scheduler: RTL
=========================

Name: pulse_sync_scheduler

Overview:
- Source-domain scheduler that shares one slow-to-fast pulse synchronizer among N_REQ requesters.
- Counts each requester's pending single-cycle request strobes.
- Selects among pending requesters by round-robin and issues one-cycle pulses to the synchronizer input, enforcing a programmable idle gap so no two pulses merge or get lost across the crossing.
- Presents the granted channel ID alongside each pulse, held stable for the whole issue window.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- CNT_W, 3, width of each pending counter; saturates at 2^CNT_W-1
- GAP, 2, idle cycles forced after each issued pulse (0..15)

Ports:
- i_clk  in  1  source-domain clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req  in  N_REQ  per-requester request strobes; each high cycle adds one pending pulse
- i_en  in  1  scheduler enable
- i_ovf_clr  in  1  clears all sticky overflow flags
- o_pulse  out  1  single-cycle pulse to the synchronizer's i_pulse
- o_chan  out  max(1,$clog2(N_REQ))  channel ID of current/last grant
- o_busy  out  1  high while in ISSUE or GAP
- o_pending_any  out  1  OR of (counter != 0) over all requesters
- o_ovf  out  N_REQ  sticky per-requester overflow flags

Behaviour:
- Reset (async assert, sync-to-clock release handled upstream) forces all of the following immediately:
  - o_pulse=0, o_chan=0, o_busy=0, o_pending_any=0, o_ovf=0
  - all counters=0, state=IDLE, gap counter=0
  - round-robin pointer so that channel 0 has highest priority
- All outputs are registered except o_pending_any, which is a direct OR of counter registers.
- Counters:
  - Next value is cnt + req - dec, where dec=1 only for the channel granted on the IDLE->ISSUE transition edge.
  - req and dec in the same cycle leave the counter unchanged.
  - At max with req=1 and dec=0: counter holds max and o_ovf[k] sets. The extra request is dropped.
  - i_ovf_clr clears o_ovf; a set in the same cycle wins.
- FSM:
  - IDLE: if i_en=1 and any counter != 0, pick the first nonzero channel starting at (last_grant+1) mod N_REQ. Latch it to o_chan, decrement its counter, go to ISSUE. Otherwise stay.
  - ISSUE: o_pulse=1 for exactly this one cycle. If GAP=0 go to IDLE, else load gap counter with GAP and go to GAP.
  - GAP: o_pulse=0. Decrement gap counter; go to IDLE when it reaches 1.
- o_pulse is never high in two consecutive cycles.
- Minimum pulse period is GAP+2 cycles.
- Latency: a req sampled at edge E0 while IDLE, enabled, with all other counters zero gives o_pulse high from edge E0+1 to E0+2.
- o_chan holds its value from ISSUE entry until the next grant; it never changes while o_busy=1.
- o_busy=1 exactly for the 1+GAP cycles of ISSUE and GAP.
- i_en=0:
  - Does not abort an in-flight ISSUE/GAP; FSM completes and parks in IDLE.
  - Counters keep accumulating.
- Round-robin pointer updates only on grant. Any continuously pending requester is granted within N_REQ grants.
- Reset mid-ISSUE or mid-GAP: the pulse is abandoned, all pending counts are lost, and no pulse issues after release without a new req.

Test Plan:
- Single request: N_REQ=4, GAP=2; i_req=4'b0100 for one cycle at edge 10 → o_pulse high edges 11–12 only, o_chan=2, o_busy high edges 11–14, o_pending_any back to 0 after edge 11.
- Simultaneous requests: i_req=4'b1111 for one cycle → four pulses with o_chan order 0,1,2,3, rising edges spaced exactly 4 cycles apart; o_pulse never high on adjacent cycles.
- Saturation: i_en=0, pulse i_req[1] for 9 cycles → counter=7, o_ovf=4'b0010. Then i_en=1 → exactly 7 pulses on chan 1. o_ovf stays set until an i_ovf_clr pulse clears it to 0.
- Fairness: i_req[0] held high continuously and i_req[3] pulsed once → grants alternate 0,3,0,0,...; channel 3 is granted within the next 2 grants. Counter 0 saturates and sets o_ovf[0].
- Collision: i_req[2] asserted in the same cycle channel 2 is granted with count=1 → count remains 1 and a second chan-2 pulse follows GAP+2 cycles later.
- Reset during GAP: assert i_rst_n=0 mid-GAP with counters 3/0/1/0 → all outputs 0 without waiting for a clock edge. After release, no pulse for 20 cycles with i_req=0.

Source files
------------

// File: rtl/pulse_sync_scheduler.sv
// Round-robin scheduler that funnels N_REQ requesters through a single slow-to-fast pulse synchronizer.
// Each issued pulse is followed by GAP idle cycles so neighbouring pulses never merge across the crossing.
module pulse_sync_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 3,
  parameter int GAP   = 2,
  localparam int CH_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_en,
  input  logic             i_ovf_clr,
  output logic             o_pulse,
  output logic [CH_W-1:0]  o_chan,
  output logic             o_busy,
  output logic             o_pending_any,
  output logic [N_REQ-1:0] o_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       GAP_V   = 4'(GAP);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [N_REQ];
  logic [CH_W-1:0]  r_last;
  logic [3:0]       r_gap;

  logic             w_found;
  logic [CH_W-1:0]  w_pick;
  logic [CH_W-1:0]  w_idx;
  logic             w_grant;

  // Search starts one past the last grant, which gives every pending requester a turn within N_REQ grants.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = CH_W'((int'(r_last) + 1 + i) % N_REQ);
      if (!w_found && (r_cnt[w_idx] != '0)) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && i_en && w_found;

  always_comb begin
    o_pending_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      o_pending_any = o_pending_any | (r_cnt[i] != '0);
    end
  end

  // A request arriving at a full counter is dropped and flagged; a same-cycle set beats the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_REQ; k++) begin
        r_cnt[k] <= '0;
      end
      o_ovf <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (i_req[k] && !(w_grant && (w_pick == CH_W'(k)))) begin
          if (r_cnt[k] == CNT_MAX) begin
            o_ovf[k] <= 1'b1;
          end else begin
            r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          end
        end else if (!i_req[k] && w_grant && (w_pick == CH_W'(k))) begin
          r_cnt[k] <= r_cnt[k] - CNT_W'(1);
        end
        if (i_ovf_clr && !(i_req[k] && !(w_grant && (w_pick == CH_W'(k))) && (r_cnt[k] == CNT_MAX))) begin
          o_ovf[k] <= 1'b0;
        end
      end
    end
  end

  // Pointer starts at the last channel so channel 0 wins the first arbitration after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_last  <= CH_W'(N_REQ - 1);
      r_gap   <= '0;
      o_pulse <= 1'b0;
      o_chan  <= '0;
      o_busy  <= 1'b0;
    end else begin
      o_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_ISSUE;
            r_last  <= w_pick;
            o_chan  <= w_pick;
            o_pulse <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (GAP == 0) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_state <= S_GAP;
            r_gap   <= GAP_V;
          end
        end
        S_GAP: begin
          if (r_gap <= 4'd1) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            o_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
